pulse_seq_ctrl: RTL and testbench

//  Sequencer/arbiter for the 8x8 single-port pulse-table RAM (registered read, RW=0 read, RW=1 write).

---
 rtl/pulse_seq_pkg.sv | 25 ++
 rtl/pulse_seq_ctrl_if.sv | 25 ++
 rtl/pulse_seq_timer.sv | 57 +++++
 rtl/pulse_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pulse_seq_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse-table sequencer.
// Optional feature macro: PULSE_SEQ_CNT_EN (pulse counter output).
package pulse_seq_pkg;

    localparam int DEPTH      = 8;
    localparam int AW         = 3;
    localparam int DW         = 8;
    localparam int PULSE_W    = 4;
    localparam int MIN_PERIOD = 3;
    localparam int RD_LAT     = 2;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_e;

    function automatic logic [DW-1:0] clamp_period(input logic [DW-1:0] v);
        return (v < DW'(MIN_PERIOD)) ? DW'(MIN_PERIOD) : v;
    endfunction

endpackage

// File: rtl/pulse_seq_ctrl_if.sv
// Host table-write handshake between a host and the pulse sequencer.
// Optional feature macro: PULSE_SEQ_CNT_EN (not used here).
interface pulse_seq_ctrl_if;
    import pulse_seq_pkg::*;

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;

    modport master (
        output wr_req,
        output wr_addr,
        output wr_data,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        input  wr_data,
        output wr_ack
    );

endinterface

// File: rtl/pulse_seq_timer.sv
// Period counter and sync pulse shaper for one table entry at a time.
// Optional feature macro: PULSE_SEQ_CNT_EN (not used here).
module pulse_seq_timer
    import pulse_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          load,
    input  logic          run,
    input  logic [DW-1:0] load_val,
    output logic [DW-1:0] cnt,
    output logic          wrap,
    output logic          sync_out
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] per_q, per_d;
    logic [DW-1:0] per_m1;
    logic [DW-1:0] hi;
    logic          sync_q, sync_d;

    always_comb begin
        cnt_d = cnt_q;
        per_d = per_q;
        if (clr) begin
            cnt_d = '0;
            per_d = '0;
        end else if (load) begin
            cnt_d = '0;
            per_d = load_val;
        end else if (run) begin
            cnt_d = cnt_q + DW'(1);
        end
        // high time never reaches the last cycle, so periods stay separable
        per_m1 = per_d - DW'(1);
        hi     = (per_m1 < DW'(PULSE_W)) ? per_m1 : DW'(PULSE_W);
        sync_d = !clr && (load || run) && (cnt_d < hi);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            per_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            sync_q <= sync_d;
        end
    end

    assign cnt      = cnt_q;
    assign wrap     = (cnt_q == per_q - DW'(1));
    assign sync_out = sync_q;

endmodule

// File: rtl/pulse_seq_ctrl.sv
// Pulse-table playback sequencer and RAM port arbiter (playback reads win).
// Optional feature macro: PULSE_SEQ_CNT_EN adds the pulse_cnt output.
module pulse_seq_ctrl
    import pulse_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [AW-1:0]    last_addr,
    pulse_seq_ctrl_if.slave  host,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    output logic             ram_rw,
    input  logic [DW-1:0]    ram_dout,
    output logic             sync_out,
    output logic [AW-1:0]    cur_addr,
    output logic             busy
`ifdef PULSE_SEQ_CNT_EN
    ,
    output logic [15:0]      pulse_cnt
`endif
);

    state_e        state_q, state_d;
    logic [1:0]    prime_q, prime_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] nxt_addr_q, nxt_addr_d;
    logic [DW-1:0] nxt_per_q, nxt_per_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_din_q, ram_din_d;
    logic          ram_rw_q, ram_rw_d;
    logic          play_rd, wr_ack;
    logic          t_clr, t_load, t_run, t_wrap;
    logic [DW-1:0] t_val, t_cnt;
    logic [AW-1:0] lim, na;

    if (DEPTH < (1 << AW)) begin : g_clip
        assign lim = (last_addr > AW'(DEPTH-1)) ? AW'(DEPTH-1) : last_addr;
    end else begin : g_full
        assign lim = last_addr;
    end

    assign na = (cur_addr_q == lim) ? '0 : cur_addr_q + AW'(1);

    always_comb begin
        play_rd    = en && ((state_q == IDLE) ||
                            (state_q == RUN && t_cnt == '0));
        state_d    = state_q;
        prime_d    = prime_q;
        cur_addr_d = cur_addr_q;
        nxt_addr_d = nxt_addr_q;
        nxt_per_d  = nxt_per_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        ram_rw_d   = RW_READ;
        wr_ack     = 1'b0;
        t_clr      = 1'b0;
        t_load     = 1'b0;
        t_run      = 1'b0;
        t_val      = nxt_per_q;

        if (play_rd) begin
            ram_addr_d = (state_q == RUN) ? na : '0;
        end else if (host.wr_req) begin
            ram_rw_d   = RW_WRITE;
            ram_addr_d = host.wr_addr;
            ram_din_d  = host.wr_data;
            wr_ack     = 1'b1;
        end

        if (!en) begin
            state_d    = IDLE;
            prime_d    = '0;
            cur_addr_d = '0;
            t_clr      = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = PRIME;
                    prime_d = '0;
                end
                PRIME: begin
                    if (prime_q == 2'(RD_LAT-1)) begin
                        state_d = RUN;
                        t_load  = 1'b1;
                        t_val   = clamp_period(ram_dout);
                    end else begin
                        prime_d = prime_q + 2'd1;
                    end
                end
                RUN: begin
                    if (t_cnt == '0) nxt_addr_d = na;
                    if (t_cnt == DW'(RD_LAT))
                        nxt_per_d = clamp_period(ram_dout);
                    // a 3-cycle period wraps on the capture cycle itself
                    if (t_wrap) begin
                        t_load     = 1'b1;
                        t_val      = (t_cnt == DW'(RD_LAT)) ?
                                     clamp_period(ram_dout) : nxt_per_q;
                        cur_addr_d = nxt_addr_q;
                    end else begin
                        t_run = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prime_q    <= '0;
            cur_addr_q <= '0;
            nxt_addr_q <= '0;
            nxt_per_q  <= '0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            ram_rw_q   <= RW_READ;
        end else begin
            state_q    <= state_d;
            prime_q    <= prime_d;
            cur_addr_q <= cur_addr_d;
            nxt_addr_q <= nxt_addr_d;
            nxt_per_q  <= nxt_per_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            ram_rw_q   <= ram_rw_d;
        end
    end

    pulse_seq_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (t_clr),
        .load     (t_load),
        .run      (t_run),
        .load_val (t_val),
        .cnt      (t_cnt),
        .wrap     (t_wrap),
        .sync_out (sync_out)
    );

`ifdef PULSE_SEQ_CNT_EN
    logic [15:0] pcnt_q, pcnt_d;

    // every period load starts a fresh high phase, i.e. one rising edge
    always_comb begin
        pcnt_d = pcnt_q;
        if (state_q == IDLE && en) pcnt_d = '0;
        else if (t_load)           pcnt_d = pcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

    assign pulse_cnt = pcnt_q;
`endif

    assign host.wr_ack = wr_ack;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign ram_rw      = ram_rw_q;
    assign cur_addr    = cur_addr_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_pulse_seq_ctrl.sv
// Randomized bench for pulse_seq_ctrl against a period-list reference model.
// Define PULSE_SEQ_CNT_EN to also cover the pulse counter.
module tb_pulse_seq_ctrl;
    import pulse_seq_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [AW-1:0] last_addr = '0;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic          ram_rw;
    logic [DW-1:0] ram_dout;
    logic          sync_out;
    logic [AW-1:0] cur_addr;
    logic          busy;
`ifdef PULSE_SEQ_CNT_EN
    logic [15:0]   pulse_cnt;
`endif

    pulse_seq_ctrl_if host ();

    pulse_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .last_addr (last_addr),
        .host      (host),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_rw    (ram_rw),
        .ram_dout  (ram_dout),
        .sync_out  (sync_out),
        .cur_addr  (cur_addr),
        .busy      (busy)
`ifdef PULSE_SEQ_CNT_EN
        ,
        .pulse_cnt (pulse_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_din;
        else        ram_dout <= mem[ram_addr];
    end

    int errors = 0;
    int checks = 0;
    int tbl_a [DEPTH];
    int tbl_b [DEPTH];
    bit exp_s [$];
    int exp_a [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle sync/address from the table; tbl_b applies from period sw on.
    task automatic build(input int n, input int sw);
        int addr, k, p, hi, v, lim;
        exp_s.delete();
        exp_a.delete();
        addr = 0;
        k = 0;
        lim = (int'(last_addr) > DEPTH-1) ? DEPTH-1 : int'(last_addr);
        while (exp_s.size() < n) begin
            v = (k >= sw) ? tbl_b[addr] : tbl_a[addr];
            p = (v < MIN_PERIOD) ? MIN_PERIOD : v;
            hi = (p - 1 < PULSE_W) ? p - 1 : PULSE_W;
            for (int c = 0; c < p; c++) begin
                exp_s.push_back(c < hi);
                exp_a.push_back(addr);
            end
            addr = (addr == lim) ? 0 : addr + 1;
            k++;
        end
    endtask

    task automatic load_table();
        int w;
        en = 1'b0;
        tick();
        tick();
        for (int a = 0; a < DEPTH; a++) begin
            host.wr_req = 1'b1;
            host.wr_addr = AW'(a);
            host.wr_data = DW'(tbl_a[a]);
            #1;
            w = 0;
            while (!host.wr_ack && w < 4) begin
                tick();
                w++;
            end
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL load_ack addr %0d: waited %0d, want 0", a, w);
            end
            tick();
        end
        host.wr_req = 1'b0;
        tbl_b = tbl_a;
    endtask

    task automatic start_run();
        en = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        checks++;
        if ({sync_out, cur_addr, busy, ram_rw, ram_addr, ram_din} !== '0) begin
            errors++;
            $display("FAIL reset_init: outputs %0h, want 0",
                     {sync_out, cur_addr, busy, ram_rw, ram_addr, ram_din});
        end
        rst_n = 1'b1;
        tick();
        tbl_a = '{10, 20, 5, 9, 8, 7, 6, 4};
        last_addr = 3'd2;
        load_table();
        start_run();
        repeat (14) tick();
        en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sync_out, cur_addr, busy, ram_rw, ram_addr, ram_din} !== '0) begin
            errors++;
            $display("FAIL reset_midrun: outputs %0h, want 0",
                     {sync_out, cur_addr, busy, ram_rw, ram_addr, ram_din});
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || sync_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: busy %b sync %b, want 0 0", busy, sync_out);
        end
        en = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (sync_out !== (c == 3) || busy !== 1'b1) begin
                errors++;
                $display("FAIL start_latency cyc %0d: sync %b busy %b, want %b 1",
                         c, sync_out, busy, c == 3);
            end
        end
    endtask

    task automatic test_table();
        tbl_a = '{10, 20, 5, 0, 0, 0, 0, 0};
        for (int a = 3; a < DEPTH; a++) tbl_a[a] = int'($urandom_range(0, 255));
        last_addr = 3'd2;
        load_table();
        build(85, 1000);
        start_run();
        for (int i = 0; i < 85; i++) begin
            #1;
            checks++;
            if (sync_out !== exp_s[i] || cur_addr !== AW'(exp_a[i])) begin
                errors++;
                $display("FAIL table cyc %0d: sync %b addr %0d, want %b %0d",
                         i, sync_out, cur_addr, exp_s[i], exp_a[i]);
            end
            tick();
        end
    endtask

    task automatic test_small();
        tbl_a = '{0, 1, 2, 40, 40, 40, 40, 40};
        last_addr = 3'd2;
        load_table();
        build(30, 1000);
        start_run();
        for (int i = 0; i < 30; i++) begin
            #1;
            checks++;
            if (sync_out !== exp_s[i] || cur_addr !== AW'(exp_a[i])) begin
                errors++;
                $display("FAIL small cyc %0d: sync %b addr %0d, want %b %0d",
                         i, sync_out, cur_addr, exp_s[i], exp_a[i]);
            end
            tick();
        end
    endtask

    task automatic test_write();
        int s;
        tbl_a = '{10, 20, 5, 30, 30, 30, 30, 30};
        last_addr = 3'd2;
        load_table();
        tbl_b[2] = 7;
        build(80, 3);
        s = 10;
        start_run();
        for (int i = 0; i < 80; i++) begin
            if (i == s) begin
                host.wr_req = 1'b1;
                host.wr_addr = 3'd2;
                host.wr_data = 8'd7;
            end
            if (i == s + 2) host.wr_req = 1'b0;
            #1;
            if (i == s) begin
                checks++;
                if (host.wr_ack !== 1'b0) begin
                    errors++;
                    $display("FAIL write_blocked: ack %b, want 0", host.wr_ack);
                end
            end
            if (i == s + 1) begin
                checks++;
                if (host.wr_ack !== 1'b1) begin
                    errors++;
                    $display("FAIL write_ack: ack %b, want 1", host.wr_ack);
                end
            end
            if (i == s + 2) begin
                checks++;
                if ({ram_rw, ram_addr, ram_din} !== {1'b1, 3'd2, 8'd7}) begin
                    errors++;
                    $display("FAIL write_bus: rw %b addr %0d din %0d, want 1 2 7",
                             ram_rw, ram_addr, ram_din);
                end
            end
            checks++;
            if (sync_out !== exp_s[i] || cur_addr !== AW'(exp_a[i])) begin
                errors++;
                $display("FAIL write_play cyc %0d: sync %b addr %0d, want %b %0d",
                         i, sync_out, cur_addr, exp_s[i], exp_a[i]);
            end
            tick();
        end
    endtask

    task automatic test_stop();
        tbl_a = '{10, 12, 14, 3, 3, 3, 3, 3};
        last_addr = 3'd2;
        load_table();
        build(10, 1000);
        start_run();
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (sync_out !== exp_s[i] || busy !== 1'b1) begin
                errors++;
                $display("FAIL stop_pre cyc %0d: sync %b busy %b, want %b 1",
                         i, sync_out, busy, exp_s[i]);
            end
            if (i == 7) en = 1'b0;
            tick();
        end
        checks++;
        if (sync_out !== 1'b0 || cur_addr !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop: sync %b addr %0d busy %b, want 0 0 0",
                     sync_out, cur_addr, busy);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            for (int a = 0; a < DEPTH; a++) tbl_a[a] = int'($urandom_range(0, 24));
            last_addr = AW'($urandom_range(0, DEPTH-1));
            load_table();
            build(150, 1000);
            start_run();
            for (int i = 0; i < 150; i++) begin
                #1;
                checks++;
                if (sync_out !== exp_s[i] || cur_addr !== AW'(exp_a[i]) || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL random it %0d cyc %0d: sync %b addr %0d, want %b %0d",
                             it, i, sync_out, cur_addr, exp_s[i], exp_a[i]);
                end
                tick();
            end
        end
    endtask

`ifdef PULSE_SEQ_CNT_EN
    task automatic test_cnt();
        int rises;
        tbl_a = '{3, 4, 5, 9, 9, 9, 9, 9};
        last_addr = 3'd2;
        load_table();
        build(24, 1000);
        rises = 0;
        for (int i = 0; i < 24; i++)
            if (exp_s[i] && (i == 0 || !exp_s[i-1])) rises++;
        start_run();
        repeat (23) tick();
        #1;
        checks++;
        if (pulse_cnt !== 16'(rises)) begin
            errors++;
            $display("FAIL pulse_cnt: got %0d, want %0d", pulse_cnt, rises);
        end
        en = 1'b0;
        tick();
        en = 1'b1;
        tick();
        checks++;
        if (pulse_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pulse_cnt_restart: got %0d, want 0", pulse_cnt);
        end
        repeat (2) tick();
        checks++;
        if (pulse_cnt !== 16'd1) begin
            errors++;
            $display("FAIL pulse_cnt_first: got %0d, want 1", pulse_cnt);
        end
    endtask
`endif

    initial begin
        host.wr_req = 1'b0;
        host.wr_addr = '0;
        host.wr_data = '0;
        #3;
        test_reset();
        test_table();
        test_small();
        test_write();
        test_stop();
        test_random();
`ifdef PULSE_SEQ_CNT_EN
        test_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
